// File: rtl/memref_pkg.sv
// Shared types for the memref_bank HIR memory responder and its drain stream.
package memref_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DONE  = 2'd3
    } drain_state_t;

endpackage

// File: rtl/memref_bank_ram.sv
// WIDTH x SIZE register array: one write port, one registered read port,
// read-before-write when both ports hit the same address on one edge.
module memref_bank_ram #(
    parameter int WIDTH  = 32,
    parameter int SIZE   = 1024,
    parameter int ADDR_W = $clog2(SIZE)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [SIZE];

    // NOTE: the array and its read register have no reset so the storage maps
    // onto plain flops or RAM macros; callers must gate out-of-range addresses.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/memref_bank.sv
// Synchronous memory responder for one HIR memref port plus a valid/ready
// full-array drain stream. Optional protocol checking: MEMREF_BANK_CHECK_EN.
module memref_bank
    import memref_pkg::*;
#(
    parameter  int WIDTH  = 32,
    parameter  int SIZE   = 1024,
    localparam int ADDR_W = $clog2(SIZE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_addr_en,
    input  logic [ADDR_W-1:0] p0_addr_data,
    input  logic              p0_rd_en,
    output logic [WIDTH-1:0]  p0_rd_data,
    input  logic              p0_wr_en,
    input  logic [WIDTH-1:0]  p0_wr_data,
    input  logic              drain_start,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [ADDR_W-1:0] dout_addr,
    output logic [WIDTH-1:0]  dout_data,
    output logic              drain_busy,
    output logic              drain_done,
    output logic              err
);

    // One extra bit so SIZE itself is representable when SIZE is a power of two.
    localparam logic [ADDR_W:0]   SIZE_EXT = (ADDR_W + 1)'(SIZE);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(SIZE - 1);

    drain_state_t      state;
    logic [ADDR_W-1:0] idx;

    logic              addr_ok;
    logic              kernel_access;
    logic              drain_fetch;
    logic              ram_we;
    logic              ram_re;
    logic [ADDR_W-1:0] ram_raddr;
    logic [WIDTH-1:0]  ram_rdata;

    logic              kernel_rd_q;
    logic              oor_rd_q;
    logic              drain_rd_q;
    logic [WIDTH-1:0]  rd_hold;
    logic [WIDTH-1:0]  dout_hold;

    assign addr_ok       = {1'b0, p0_addr_data} < SIZE_EXT;
    assign kernel_access = p0_rd_en | p0_wr_en;
    assign drain_fetch   = (state == FETCH) && !kernel_access;

    // Kernel port owns the read port whenever it reads; drain fetches only stall.
    assign ram_we    = p0_wr_en && addr_ok;
    assign ram_re    = (p0_rd_en && addr_ok) || drain_fetch;
    assign ram_raddr = p0_rd_en ? p0_addr_data : idx;

    memref_bank_ram #(
        .WIDTH  (WIDTH),
        .SIZE   (SIZE),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (p0_addr_data),
        .wdata (p0_wr_data),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    // NOTE: all state updates use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (drain_start) begin
                        state <= FETCH;
                        idx   <= '0;
                    end
                end
                FETCH: begin
                    if (!kernel_access) begin
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (dout_ready) begin
                        if (idx == LAST_IDX) begin
                            state <= DONE;
                        end else begin
                            idx   <= idx + ADDR_W'(1);
                            state <= FETCH;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // The shared read register serves both consumers, so each output shows it
    // only in the cycle after its own read and otherwise replays its last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            kernel_rd_q <= 1'b0;
            oor_rd_q    <= 1'b0;
            drain_rd_q  <= 1'b0;
            rd_hold     <= '0;
            dout_hold   <= '0;
        end else begin
            kernel_rd_q <= p0_rd_en && addr_ok;
            oor_rd_q    <= p0_rd_en && !addr_ok;
            drain_rd_q  <= drain_fetch;
            rd_hold     <= p0_rd_data;
            dout_hold   <= dout_data;
        end
    end

    assign p0_rd_data = kernel_rd_q ? ram_rdata : (oor_rd_q ? '0 : rd_hold);
    assign dout_data  = drain_rd_q ? ram_rdata : dout_hold;
    assign dout_valid = (state == HOLD);
    assign dout_addr  = idx;
    assign drain_busy = (state == FETCH) || (state == HOLD);
    assign drain_done = (state == DONE);

`ifdef MEMREF_BANK_CHECK_EN
    logic violation;
    logic err_q;

    assign violation = (p0_rd_en && p0_wr_en)
                     || (kernel_access && !addr_ok)
                     || (kernel_access && !p0_addr_en);

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (violation) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;

`ifndef SYNTHESIS
    longint unsigned cycle_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 64'd1;
            if (violation) begin
                $error("memref_bank: port protocol violation at cycle %0d", cycle_cnt);
            end
        end
    end
`endif
`else
    logic addr_en_unused;

    assign addr_en_unused = p0_addr_en;
    assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_memref_bank.sv
// Directed self-checking bench for memref_bank (SIZE=1000, non power of two).
module tb_memref_bank;

    localparam int WIDTH  = 32;
    localparam int SIZE   = 1000;
    localparam int ADDR_W = $clog2(SIZE);

`ifdef MEMREF_BANK_CHECK_EN
    localparam logic CHECK_EN = 1'b1;
`else
    localparam logic CHECK_EN = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              p0_addr_en;
    logic [ADDR_W-1:0] p0_addr_data;
    logic              p0_rd_en;
    logic [WIDTH-1:0]  p0_rd_data;
    logic              p0_wr_en;
    logic [WIDTH-1:0]  p0_wr_data;
    logic              drain_start;
    logic              dout_valid;
    logic              dout_ready;
    logic [ADDR_W-1:0] dout_addr;
    logic [WIDTH-1:0]  dout_data;
    logic              drain_busy;
    logic              drain_done;
    logic              err;

    int n_checks = 0;
    int n_fail   = 0;

    memref_bank #(
        .WIDTH (WIDTH),
        .SIZE  (SIZE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .p0_addr_en   (p0_addr_en),
        .p0_addr_data (p0_addr_data),
        .p0_rd_en     (p0_rd_en),
        .p0_rd_data   (p0_rd_data),
        .p0_wr_en     (p0_wr_en),
        .p0_wr_data   (p0_wr_data),
        .drain_start  (drain_start),
        .dout_valid   (dout_valid),
        .dout_ready   (dout_ready),
        .dout_addr    (dout_addr),
        .dout_data    (dout_data),
        .drain_busy   (drain_busy),
        .drain_done   (drain_done),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic kwrite(input int addr, input logic [WIDTH-1:0] data);
        p0_addr_en   = 1'b1;
        p0_addr_data = ADDR_W'(addr);
        p0_wr_data   = data;
        p0_wr_en     = 1'b1;
        tick();
        p0_wr_en   = 1'b0;
        p0_addr_en = 1'b0;
    endtask

    task automatic kread(input int addr);
        p0_addr_en   = 1'b1;
        p0_addr_data = ADDR_W'(addr);
        p0_rd_en     = 1'b1;
        tick();
        p0_rd_en   = 1'b0;
        p0_addr_en = 1'b0;
    endtask

    task automatic check_reset_outputs(input string phase);
        check({phase, "_rd_data"}, 64'(p0_rd_data), 64'd0);
        check({phase, "_valid"},   64'(dout_valid), 64'd0);
        check({phase, "_addr"},    64'(dout_addr),  64'd0);
        check({phase, "_data"},    64'(dout_data),  64'd0);
        check({phase, "_busy"},    64'(drain_busy), 64'd0);
        check({phase, "_done"},    64'(drain_done), 64'd0);
        check({phase, "_err"},     64'(err),        64'd0);
    endtask

    initial begin
        int n;
        int words;
        int done_cnt;
        int first_done;
        int ka;
        int kexp;
        logic kpend;
        logic hold_pend;
        logic [ADDR_W-1:0] prev_addr;
        logic [WIDTH-1:0]  prev_data;
        logic pulsed;
        int seen_bad;

        rst          = 1'b1;
        p0_addr_en   = 1'b0;
        p0_addr_data = '0;
        p0_rd_en     = 1'b0;
        p0_wr_en     = 1'b0;
        p0_wr_data   = '0;
        drain_start  = 1'b0;
        dout_ready   = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_reset_outputs("reset");

        // Write then read one cycle later; data appears right after the read edge.
        kwrite(5, 32'hDEADBEEF);
        check("pre_read_rd_data", 64'(p0_rd_data), 64'd0);
        kread(5);
        check("rd_latency1", 64'(p0_rd_data), 64'hDEADBEEF);
        tick();
        check("rd_hold", 64'(p0_rd_data), 64'hDEADBEEF);
        check("err_clean", 64'(err), 64'd0);

        // Same-cycle read and write to one address returns the old word.
        kwrite(7, 32'h11);
        p0_addr_en   = 1'b1;
        p0_addr_data = ADDR_W'(7);
        p0_wr_data   = 32'h22;
        p0_rd_en     = 1'b1;
        p0_wr_en     = 1'b1;
        tick();
        p0_rd_en   = 1'b0;
        p0_wr_en   = 1'b0;
        p0_addr_en = 1'b0;
        check("rbw_old_data", 64'(p0_rd_data), 64'h11);
        check("rbw_err", 64'(err), 64'(CHECK_EN));
        kread(7);
        check("rbw_new_data", 64'(p0_rd_data), 64'h22);

        // Address SIZE is out of range: write dropped, read returns zero.
        kwrite(SIZE, 32'hBAD0BAD0);
        check("oor_err", 64'(err), 64'(CHECK_EN));
        kread(7);
        check("oor_keep7", 64'(p0_rd_data), 64'h22);
        kread(SIZE);
        check("oor_rd_zero", 64'(p0_rd_data), 64'd0);
        kread(5);
        check("oor_keep5", 64'(p0_rd_data), 64'hDEADBEEF);
        kread(SIZE - 1);
        check("last_addr_unwritten_ok", 64'(p0_rd_data !== 32'hBAD0BAD0), 64'd1);

        // Preload mem[i] = i, then drain at full rate.
        for (int i = 0; i < SIZE; i++) begin
            kwrite(i, WIDTH'(i));
        end
        dout_ready  = 1'b1;
        drain_start = 1'b1;
        tick();
        drain_start = 1'b0;
        check("drain_busy_start", 64'(drain_busy), 64'd1);
        n = 0; words = 0; done_cnt = 0; first_done = -1;
        while (n < 4 * SIZE) begin
            if (dout_valid && dout_ready) begin
                check("drain_addr", 64'(dout_addr), 64'(words));
                check("drain_data", 64'(dout_data), 64'(words));
                check("drain_rate", 64'(n), 64'(2 * words + 1));
                words++;
            end
            if (drain_done) begin
                done_cnt++;
                if (first_done < 0) first_done = n;
            end
            if (first_done >= 0 && n >= first_done + 2) break;
            tick();
            n++;
        end
        check("drain_words", 64'(words), 64'(SIZE));
        check("drain_done_cnt", 64'(done_cnt), 64'd1);
        check("drain_done_cycle", 64'(first_done), 64'(2 * SIZE));
        check("drain_busy_end", 64'(drain_busy), 64'd0);

        // Random backpressure with kernel reads every third cycle.
        drain_start = 1'b1;
        tick();
        drain_start = 1'b0;
        n = 0; words = 0; done_cnt = 0; first_done = -1;
        ka = 3; kexp = 0; kpend = 1'b0; hold_pend = 1'b0;
        prev_addr = '0; prev_data = '0;
        while (n < 20 * SIZE) begin
            if (kpend) begin
                check("kern_rd", 64'(p0_rd_data), 64'(kexp));
                kpend = 1'b0;
            end
            if (hold_pend) begin
                check("stall_valid", 64'(dout_valid), 64'd1);
                check("stall_addr",  64'(dout_addr),  64'(prev_addr));
                check("stall_data",  64'(dout_data),  64'(prev_data));
                hold_pend = 1'b0;
            end
            if (n % 3 == 0 && first_done < 0) begin
                p0_addr_en   = 1'b1;
                p0_addr_data = ADDR_W'(ka);
                p0_rd_en     = 1'b1;
                kexp  = ka;
                kpend = 1'b1;
                ka    = (ka + 37) % SIZE;
            end else begin
                p0_rd_en   = 1'b0;
                p0_addr_en = 1'b0;
            end
            dout_ready = 1'($urandom_range(0, 1));
            if (dout_valid) begin
                if (dout_ready) begin
                    check("bp_addr", 64'(dout_addr), 64'(words));
                    check("bp_data", 64'(dout_data), 64'(words));
                    words++;
                end else begin
                    hold_pend = 1'b1;
                    prev_addr = dout_addr;
                    prev_data = dout_data;
                end
            end
            if (drain_done) begin
                done_cnt++;
                if (first_done < 0) first_done = n;
            end
            if (first_done >= 0 && n >= first_done + 2) break;
            tick();
            n++;
        end
        p0_rd_en   = 1'b0;
        p0_addr_en = 1'b0;
        check("bp_words", 64'(words), 64'(SIZE));
        check("bp_done_cnt", 64'(done_cnt), 64'd1);

        // Reset after ten drained words aborts; a stray drain_start mid-drain is ignored.
        dout_ready  = 1'b1;
        drain_start = 1'b1;
        tick();
        drain_start = 1'b0;
        n = 0; words = 0; pulsed = 1'b0;
        while (words < 10 && n < 200) begin
            if (dout_valid && dout_ready) begin
                check("abort_addr", 64'(dout_addr), 64'(words));
                check("abort_data", 64'(dout_data), 64'(words));
                words++;
            end
            if (words == 5 && !pulsed) begin
                drain_start = 1'b1;
                pulsed      = 1'b1;
            end else begin
                drain_start = 1'b0;
            end
            tick();
            n++;
        end
        drain_start = 1'b0;
        check("abort_words", 64'(words), 64'd10);
        rst = 1'b1;
        tick();
        check_reset_outputs("midrst");
        rst = 1'b0;
        seen_bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (drain_done || dout_valid || drain_busy) seen_bad++;
        end
        check("no_done_after_rst", 64'(seen_bad), 64'd0);

        drain_start = 1'b1;
        tick();
        drain_start = 1'b0;
        n = 0; words = 0;
        while (words < 2 && n < 50) begin
            if (dout_valid && dout_ready) begin
                check("restart_addr", 64'(dout_addr), 64'(words));
                check("restart_data", 64'(dout_data), 64'(words));
                words++;
            end
            tick();
            n++;
        end
        check("restart_words", 64'(words), 64'd2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
